// File: rtl/ice51_uart_loader_if.sv
// Loader-to-core bus: code-memory write port plus the run-phase receive handshake.
// The loader drives the master modport; the core and code memory use the slave modport.
interface ice51_uart_loader_if #(
    parameter int ADDR_W = 10
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ack;

    modport master (
        output mem_we, mem_addr, mem_data, rx_valid, rx_data,
        input  rx_ack
    );

    modport slave (
        input  mem_we, mem_addr, mem_data, rx_valid, rx_data,
        output rx_ack
    );
endinterface

// File: rtl/ice51_uart_loader.sv
// 8N1 UART receiver that boot-loads code memory, then feeds later bytes to the core.
// Define ICE51_PRELOAD_EN to drop the load phase (memory initialised at elaboration).
module ice51_uart_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int MEM_SIZE     = 1024,
    parameter int ADDR_W       = 10
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_uart_rx,
    ice51_uart_loader_if.master       bus,
    output logic                      o_run,
    output logic                      o_frame_err,
    output logic                      o_rx_overrun
);
    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           state;
    logic             rx_s1, rx_s2, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             stop_tick;
    logic             byte_ok;

`ifndef ICE51_PRELOAD_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [ADDR_W-1:0] load_cnt;

    assign bus.mem_we   = mem_we;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_data = mem_data;
`else
    assign bus.mem_we   = 1'b0;
    assign bus.mem_addr = '0;
    assign bus.mem_data = '0;
`endif

    assign bus.rx_valid = rx_valid;
    assign bus.rx_data  = rx_data;

    // Stop bit is sampled on this edge; a high line completes the byte.
    assign stop_tick = (state == S_STOP) && (cnt == BIT_LAST);
    assign byte_ok   = stop_tick && rx_s2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_prev      <= 1'b1;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            o_run        <= 1'b0;
            o_frame_err  <= 1'b0;
            o_rx_overrun <= 1'b0;
`ifndef ICE51_PRELOAD_EN
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            load_cnt     <= '0;
`endif
        end else begin
            rx_s1        <= i_uart_rx;
            rx_s2        <= rx_s1;
            rx_prev      <= rx_s2;
            o_frame_err  <= 1'b0;
            o_rx_overrun <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Only a genuine 1->0 edge starts a frame, so a line stuck low is ignored.
                    if (rx_prev && !rx_s2) begin
                        state   <= S_START;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        state <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (stop_tick) begin
                        state       <= S_IDLE;
                        o_frame_err <= !rx_s2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

`ifdef ICE51_PRELOAD_EN
            o_run <= 1'b1;
`else
            mem_we <= 1'b0;
            if (mem_we && (mem_addr == LAST_ADDR)) o_run <= 1'b1;
            if (byte_ok && !o_run) begin
                mem_we   <= 1'b1;
                mem_addr <= load_cnt;
                mem_data <= shreg;
                load_cnt <= load_cnt + 1'b1;
            end
`endif

            // A new byte beats a same-cycle ack; without an ack it overwrites and flags overrun.
            if (byte_ok && o_run) begin
                rx_data      <= shreg;
                rx_valid     <= 1'b1;
                o_rx_overrun <= rx_valid && !bus.rx_ack;
            end else if (rx_valid && bus.rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ice51_uart_loader.sv
// Directed bench for ice51_uart_loader: load table, framing error, glitch, reset abort, run handshake.
`timescale 1ns/1ps
module tb_ice51_uart_loader;
    localparam int C = 104;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic run, fe, ov;

    always #5 clk = ~clk;

    ice51_uart_loader_if #(.ADDR_W(4)) bus ();

    ice51_uart_loader #(.CLKS_PER_BIT(C), .MEM_SIZE(4), .ADDR_W(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_uart_rx    (rx),
        .bus          (bus.master),
        .o_run        (run),
        .o_frame_err  (fe),
        .o_rx_overrun (ov)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0, we_cnt = 0, fe_cnt = 0, ov_cnt = 0;
    int last_we_cyc = 0, run_rise_cyc = 0;
    logic [3:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic run_q = 1'b0;
    logic got;
    int we0, fe0, ov0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        run_q <= run;
        if (bus.mem_we) begin
            we_cnt      <= we_cnt + 1;
            last_addr   <= bus.mem_addr;
            last_data   <= bus.mem_data;
            last_we_cyc <= cyc;
        end
        if (fe) fe_cnt <= fe_cnt + 1;
        if (ov) ov_cnt <= ov_cnt + 1;
        if (run && !run_q) run_rise_cyc <= cyc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int idle);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rx = d[b];
            repeat (C) @(negedge clk);
        end
        rx = stop_bit;
        repeat (C) @(negedge clk);
        rx = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_we;
        logic [3:0] exp_addr;
        logic       exp_fe;
        logic       exp_run;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h12, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[1] = '{8'h5A, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[3] = '{8'h12, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[4] = '{8'h34, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[5] = '{8'h56, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0};
        vecs[6] = '{8'h78, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1};

        bus.rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_we",   32'(bus.mem_we),   32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_data", 32'(bus.mem_data), 32'd0);
        check("rst_run",      32'(run),          32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_data",  32'(bus.rx_data),  32'd0);
        check("rst_frame_err",32'(fe),           32'd0);
        check("rst_overrun",  32'(ov),           32'd0);
        rst = 1'b0;

`ifdef ICE51_PRELOAD_EN
        @(negedge clk);
        check("pre_run", 32'(run), 32'd1);
        send_frame(8'h7E, 1'b1, C / 2);
        check("pre_valid", 32'(bus.rx_valid), 32'd1);
        check("pre_data",  32'(bus.rx_data),  32'h7E);
        check("pre_no_we", 32'(we_cnt),       32'd0);
`else
        repeat (5) @(negedge clk);
        // 20-cycle low pulse: shorter than half a bit, so it must be dropped.
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (3 * C) @(negedge clk);
        check("glitch_no_we", 32'(we_cnt), 32'd0);
        check("glitch_no_fe", 32'(fe_cnt), 32'd0);

        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                // Abort a frame mid-byte with reset; the load must restart at address 0.
                we0 = we_cnt;
                rx = 1'b0;
                repeat (C) @(negedge clk);
                for (int b = 0; b < 4; b++) begin
                    rx = b[0];
                    repeat (C) @(negedge clk);
                end
                rst = 1'b1;
                rx  = 1'b1;
                repeat (2) @(negedge clk);
                check("abort_addr", 32'(bus.mem_addr), 32'd0);
                rst = 1'b0;
                repeat (2 * C) @(negedge clk);
                check("abort_no_we", 32'(we_cnt - we0), 32'd0);
                check("abort_run",   32'(run),          32'd0);
            end
            we0 = we_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].stop ? C / 2 : C);
            check($sformatf("v%0d_we", i), 32'(we_cnt - we0), 32'(vecs[i].exp_we));
            check($sformatf("v%0d_fe", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d_addr", i), 32'(last_addr), 32'(vecs[i].exp_addr));
                check($sformatf("v%0d_data", i), 32'(last_data), 32'(vecs[i].data));
            end
            check($sformatf("v%0d_run", i), 32'(run), 32'(vecs[i].exp_run));
            check($sformatf("v%0d_valid", i), 32'(bus.rx_valid), 32'd0);
        end
        check("run_latency", 32'(run_rise_cyc - last_we_cyc), 32'd1);
        check("hold_addr", 32'(bus.mem_addr), 32'd3);
        check("hold_data", 32'(bus.mem_data), 32'h78);

        // Run handshake: ack five cycles after valid, valid must fall on the next edge.
        we0 = we_cnt;
        got = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, C / 2);
            begin
                for (int k = 0; k < 12 * C; k++) begin
                    @(negedge clk);
                    if (bus.rx_valid) begin
                        got = 1'b1;
                        break;
                    end
                end
                check("hs_valid_seen", 32'(got), 32'd1);
                if (got) begin
                    repeat (5) @(negedge clk);
                    check("hs_data",      32'(bus.rx_data),  32'hA5);
                    check("hs_valid_pre", 32'(bus.rx_valid), 32'd1);
                    bus.rx_ack = 1'b1;
                    @(negedge clk);
                    bus.rx_ack = 1'b0;
                    check("hs_valid_post", 32'(bus.rx_valid), 32'd0);
                end
            end
        join

        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 2);
        check("ov_first_data", 32'(bus.rx_data), 32'h11);
        send_frame(8'h22, 1'b1, C / 2);
        check("ov_pulses", 32'(ov_cnt - ov0),  32'd1);
        check("ov_data",   32'(bus.rx_data),   32'h22);
        check("ov_valid",  32'(bus.rx_valid),  32'd1);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        check("ov_cleared", 32'(bus.rx_valid), 32'd0);

        // Ack while nothing is valid must not disturb the next byte.
        bus.rx_ack = 1'b1;
        repeat (2) @(negedge clk);
        bus.rx_ack = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h66, 1'b1, C / 2);
        check("idle_ack_valid", 32'(bus.rx_valid), 32'd1);
        check("idle_ack_data",  32'(bus.rx_data),  32'h66);
        check("idle_ack_ov",    32'(ov_cnt - ov0), 32'd0);
        check("run_no_we",      32'(we_cnt - we0), 32'd0);
        check("run_held",       32'(run),          32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
